// File: rtl/compensation_weight_loader.sv
// Streams ROWS words of per-column 3-bit compensation weights from memory into the CPE chain, bottom row first.
// Optional build macro COMP_WEIGHT_PARITY_EN adds per-weight even-parity checking and the parity_err output.
module compensation_weight_loader #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
`ifdef COMP_WEIGHT_PARITY_EN
  input  logic [COLS*4-1:0]   mem_rd_data,
`else
  input  logic [COLS*3-1:0]   mem_rd_data,
`endif
  output logic [COLS*3-1:0]   Compensation_Weight,
  output logic                Compensation_Weight_out_valid
`ifdef COMP_WEIGHT_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing ROWS memory reads, top address first
  // DRAIN | 2 cycles while the last reads return and shift out
  // DONE  | one-cycle completion pulse; start ignored here

  localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               rd_en_q;
  logic               accept;
  logic [COLS*3-1:0]  weight_rd;
  logic               parity_bad;

  assign accept = (state == IDLE) && start;

`ifdef COMP_WEIGHT_PARITY_EN
  always_comb begin
    weight_rd  = '0;
    parity_bad = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      weight_rd[3*c +: 3] = mem_rd_data[4*c +: 3];
      parity_bad          = parity_bad | (^mem_rd_data[4*c +: 4]);
    end
  end
`else
  always_comb begin
    weight_rd  = mem_rd_data;
    parity_bad = 1'b0;
  end
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = READ;
          cnt_nx   = CNT_W'(ROWS - 1);
        end
      end
      READ: begin
        if (cnt == '0) begin
          state_nx = DRAIN;
          cnt_nx   = CNT_W'(1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                         <= IDLE;
      cnt                           <= '0;
      busy                          <= 1'b0;
      done                          <= 1'b0;
      mem_rd_en                     <= 1'b0;
      mem_rd_addr                   <= '0;
      rd_en_q                       <= 1'b0;
      Compensation_Weight           <= '0;
      Compensation_Weight_out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
      mem_rd_en <= (state_nx == READ);
      // Bottom row goes first so it has been shifted furthest when the load ends.
      if (accept)              mem_rd_addr <= base_addr + ADDR_W'(ROWS - 1);
      else if (state == READ)  mem_rd_addr <= mem_rd_addr - 1'b1;
      rd_en_q                       <= mem_rd_en;
      Compensation_Weight_out_valid <= rd_en_q;
      Compensation_Weight           <= rd_en_q ? weight_rd : '0;
    end
  end

`ifdef COMP_WEIGHT_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                      parity_err <= 1'b0;
    else if (accept)                 parity_err <= 1'b0;
    else if (rd_en_q && parity_bad)  parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_compensation_weight_loader.sv
// Directed bench for compensation_weight_loader (ROWS=4, COLS=2, ADDR_W=8) with a 1-cycle sync memory model.
module tb_compensation_weight_loader;
  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int AW   = 8;
`ifdef COMP_WEIGHT_PARITY_EN
  localparam int DW = COLS*4;
`else
  localparam int DW = COLS*3;
`endif

  logic clk = 1'b0;
  logic rst_n, start;
  logic [AW-1:0] base_addr;
  logic busy, done, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [COLS*3-1:0] weight;
  logic valid;
`ifdef COMP_WEIGHT_PARITY_EN
  logic parity_err;
`endif

  compensation_weight_loader #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .Compensation_Weight(weight),
    .Compensation_Weight_out_valid(valid)
`ifdef COMP_WEIGHT_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] enc(input logic [5:0] w);
    logic [DW-1:0] r;
    r = '0;
`ifdef COMP_WEIGHT_PARITY_EN
    for (int c = 0; c < COLS; c++) begin
      r[4*c +: 3] = w[3*c +: 3];
      r[4*c + 3]  = ^w[3*c +: 3];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  typedef struct {
    logic       rd_en;
    logic [7:0] addr;
    logic       vld;
    logic [5:0] wt;
    logic       bsy;
    logic       dn;
  } vec_t;
  vec_t tbl [16];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    base_addr = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Pulses start, then checks cycles T1..T8 against table rows first..first+7.
  task automatic run_load(input logic [7:0] b, input int first);
    do_start(b);
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      v = tbl[first + k];
      chk($sformatf("rd_en[%0d]", first + k), mem_rd_en, v.rd_en);
      if (v.rd_en) chk($sformatf("rd_addr[%0d]", first + k), mem_rd_addr, v.addr);
      chk($sformatf("valid[%0d]", first + k), valid, v.vld);
      chk($sformatf("weight[%0d]", first + k), weight, v.wt);
      chk($sformatf("busy[%0d]", first + k), busy, v.bsy);
      chk($sformatf("done[%0d]", first + k), done, v.dn);
      step();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_rd_en"}, mem_rd_en, 1'b0);
    chk({name, "_addr"}, mem_rd_addr, 8'h00);
    chk({name, "_valid"}, valid, 1'b0);
    chk({name, "_weight"}, weight, 6'o00);
  endtask

  initial begin
    int beats, dones, nrise, low_gap;
    int rise [4];
    logic prev;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = enc(6'o01); mem[8'h11] = enc(6'o23);
    mem[8'h12] = enc(6'o45); mem[8'h13] = enc(6'o67);
    mem[8'h01] = enc(6'o76); mem[8'h00] = enc(6'o54);
    mem[8'hFF] = enc(6'o32); mem[8'hFE] = enc(6'o10);

    // basic load, base 0x10
    tbl[0]  = '{1'b1, 8'h13, 1'b0, 6'o00, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 6'o00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 6'o67, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h10, 1'b1, 6'o45, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 6'o23, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 6'o01, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 6'o00, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 6'o00, 1'b0, 1'b0};
    // wrap load, base 0xFE
    tbl[8]  = '{1'b1, 8'h01, 1'b0, 6'o00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 6'o00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 8'hFF, 1'b1, 6'o76, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'hFE, 1'b1, 6'o54, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 6'o32, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 6'o10, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 6'o00, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 6'o00, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    repeat (3) step();
    chk_all_zero("reset");
`ifdef COMP_WEIGHT_PARITY_EN
    chk("reset_parity_err", parity_err, 1'b0);
`endif
    rst_n = 1'b1;
    step();

    run_load(8'h10, 0);
    run_load(8'hFE, 8);

    // start while busy (T2, T5) ignored; start at T8 accepted
    do_start(8'h10);
    beats = 0; dones = 0;
    for (int k = 1; k <= 8; k++) begin
      beats += valid;
      dones += done;
      start = (k == 2 || k == 5 || k == 8);
      step();
    end
    start = 1'b0;
    chk("busy_start_beats", beats, 4);
    chk("busy_start_dones", dones, 1);
    chk("restart_busy", busy, 1'b1);
    chk("restart_rd_en", mem_rd_en, 1'b1);
    chk("restart_addr", mem_rd_addr, 8'h13);
    wait_idle("restart");
    step();

    // reset in T4 aborts the load
    do_start(8'h10);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("midreset");
    dones = 0; beats = 0;
    for (int k = 0; k < 10; k++) begin
      dones += done; beats += valid;
      step();
    end
    chk("midreset_no_done", dones, 0);
    chk("midreset_no_valid", beats, 0);
    run_load(8'h10, 0);

    // start held high: loads repeat every ROWS+4 cycles
    start = 1'b1; base_addr = 8'h10;
    nrise = 0; low_gap = 0; beats = 0; prev = 1'b0;
    for (int c = 0; c < 26; c++) begin
      step();
      if (valid && !prev && nrise < 4) begin rise[nrise] = c; nrise++; end
      if (nrise == 1) begin
        if (valid) beats++;
        else       low_gap++;
      end
      prev = valid;
    end
    start = 1'b0;
    chk("b2b_rises", nrise >= 2, 1'b1);
    if (nrise >= 2) chk("b2b_period", rise[1] - rise[0], ROWS + 4);
    chk("b2b_beats", beats, ROWS);
    chk("b2b_low_gap", low_gap, 4);
    wait_idle("b2b");
    step();

`ifdef COMP_WEIGHT_PARITY_EN
    mem[8'h12] = mem[8'h12] ^ 8'h08;
    do_start(8'h10);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("parity_err_T%0d", k), parity_err, (k >= 4));
      if (k == 4) chk("parity_fwd_data", weight, 6'o45);
      step();
    end
    chk("parity_sticky", parity_err, 1'b1);
    do_start(8'h10);
    chk("parity_cleared", parity_err, 1'b0);
    wait_idle("parity");
    mem[8'h12] = enc(6'o45);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
